coin_intake: RTL
================

# coin_intake

Front-end coin acceptor stage feeding the vending controller's coin-counting inputs. It synchronizes and debounces the three raw coin-sensor lines, rejects ambiguous or overflowing insertions, and buffers accepted coins in a small FIFO. It then replays them to the controller as clean, spaced, single-cycle `inQ`/`inD`/`inN` pulses. A `hold` input lets the controller pause delivery while it vends or returns change.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive equal synchronized samples required to change a debounced line (≥1).
- `FIFO_DEPTH`, 4: coin queue depth (power of two).
- `GAP_CYCLES`, 1: minimum idle cycles between consecutive output pulses (≥1).
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `coinQ_raw`, `coinD_raw`, `coinN_raw`  in  1 each  asynchronous, bouncy sensor lines; high = coin present.
- `hold`  in  1  high = do not start a new output pulse.
- `inQ`, `inD`, `inN`  out  1 each  single-cycle coin pulses to the controller; at most one high per cycle.
- `reject`  out  1  single-cycle pulse: coin discarded.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  coins queued.
- `full`  out  1  `fifo_count == FIFO_DEPTH`.

## Operation
- Per line: 2-flop synchronizer, then debouncer. The debounce counter increments while the synced value ≠ the stable value and clears otherwise. The stable value takes the synced value when the counter reaches `DEBOUNCE_CYCLES`.
- A coin event is a 0→1 transition of a stable line.
- Exactly one event in a cycle: push a coin code (Q=1, D=2, N=3).
- Two or more events in the same cycle: no push; `reject` pulses once.
- Push while full with no pop in the same cycle: coin dropped; `reject` pulses.
- Push and pop in the same cycle: both succeed, including when full; the count is unchanged.
- Output FSM:
  - IDLE: if FIFO non-empty and `hold`=0, pop the head and go to EMIT.
  - EMIT: drive the matching output high for exactly one cycle, then go to GAP.
  - GAP: stay `GAP_CYCLES` cycles, then go to IDLE.
- `hold` is sampled only in IDLE. A pulse already in EMIT completes.
- The FIFO preserves order. Codes are 2 bits; the pointers wrap modulo `FIFO_DEPTH`.
- Reset (asynchronous, `rst`=0):
  - All outputs are 0, `fifo_count`=0, and the FSM is in IDLE.
  - Synchronizers, stable values and counters are all cleared.
  - A reset mid-operation discards queued coins and any pulse in progress.
  - A line held high through reset release registers as one coin after debounce.

## Timing
- Latency with an empty FIFO and `hold`=0: the first rising edge sampling raw high is edge 0. The sync output is high after edge 1 and the stable value sets at edge 1+`DEBOUNCE_CYCLES`. The push occurs at edge 2+`DEBOUNCE_CYCLES` and EMIT is entered at edge 3+`DEBOUNCE_CYCLES`. The output is high for the cycle following that edge (8 edges with defaults).
- Back-to-back queued coins: pulses are `GAP_CYCLES`+2 cycles apart (3 with defaults).
- Bounce: any raw glitch shorter than `DEBOUNCE_CYCLES` synced cycles produces no event.
- A falling edge produces no event. A line must be stable low before it can generate a new coin.
- `reject` asserts the cycle after the offending detection, concurrent with the failed push edge.
- `fifo_count` and `full` are registered and reflect pushes/pops of the previous edge.

## Structure
- Shared package `coin_pkg`: coin code typedef (`COIN_NONE`=0, `COIN_Q`=1, `COIN_D`=2, `COIN_N`=3), the output-FSM state enum (IDLE, EMIT, GAP), and coin value constants 25/10/5 for reuse by the counting stage.
- Sub-module `coin_debounce`: synchronizer plus debouncer plus rising-edge detect. It is parameterized by `DEBOUNCE_CYCLES` and instantiated three times.
- FIFO and output FSM are inline in `coin_intake`.

## Test plan
- Single quarter: `coinQ_raw` high for 20 cycles with defaults → exactly one `inQ` pulse, high during the cycle after edge 7. `fifo_count` returns to 0 and there is no `reject`.
- Bounce: `coinD_raw` toggles every 2 cycles for 12 cycles, then stays high → exactly one `inD` pulse; a 3-cycle glitch alone → no pulse.
- Simultaneous: `coinQ_raw` and `coinN_raw` rise on the same edge → one `reject` pulse, no `inQ`/`inN`, `fifo_count` stays 0.
- Overflow with `hold`=1: insert Q, D, N, Q, then D → `full`=1 after the fourth coin and `reject` on the fifth. Releasing `hold` gives `inQ`, `inD`, `inN`, `inQ` pulses spaced 3 cycles apart.
- Hold mid-stream: 2 coins queued, `hold` raised in the cycle of the first `inQ` pulse → the first pulse completes and the second waits until `hold`=0.
- Reset mid-operation: 3 coins queued, `rst`=0 for 1 cycle → all outputs 0 and `fifo_count`=0 immediately; no pulses after release unless a raw line is still high.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared coin codes, output-FSM states and coin values for the intake and counting stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package coin_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_Q    = 2'd1,
        COIN_D    = 2'd2,
        COIN_N    = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int unsigned COIN_VALUE_Q = 25;
    localparam int unsigned COIN_VALUE_D = 10;
    localparam int unsigned COIN_VALUE_N = 5;

    function automatic int unsigned coin_value(input coin_t c);
        case (c)
            COIN_Q:  return COIN_VALUE_Q;
            COIN_D:  return COIN_VALUE_D;
            COIN_N:  return COIN_VALUE_N;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor line: 2-flop synchronizer, debouncer, rising-edge detect of the debounced value.
// Latency: rise is high in the cycle after edge 1+DEBOUNCE_CYCLES (edge 0 = first edge sampling raw high).
// Backpressure: none; free-running, rise is a single-cycle pulse.
// Ports: clk, rst (async active-low), raw (async bouncy input), rise (debounced 0->1 pulse).
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 != stable) begin
                // The edge that would take the counter to DEBOUNCE_CYCLES flips
                // the stable value instead, so the counter never holds that value.
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/coin_intake.sv
// Coin acceptor front end: debounce three sensor lines, queue accepted coins, replay as spaced pulses.
// Latency: output pulse in the cycle after edge 3+DEBOUNCE_CYCLES from first raw-high sample (empty FIFO, hold=0).
// Backpressure: hold=1 stalls new pulses in IDLE; coins queue up to FIFO_DEPTH, overflow and ambiguous coins pulse reject.
// Ports: clk, rst (async active-low), coinQ/D/N_raw (sensor lines), hold (pause delivery),
//        inQ/inD/inN (single-cycle coin pulses), reject (coin discarded), fifo_count, full.
module coin_intake
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coinQ_raw,
    input  logic                          coinD_raw,
    input  logic                          coinN_raw,
    input  logic                          hold,
    output logic                          inQ,
    output logic                          inD,
    output logic                          inN,
    output logic                          reject,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          full
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // ---------------- event detection ----------------
    logic rise_q;
    logic rise_d;
    logic rise_n;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_q (
        .clk  (clk),
        .rst  (rst),
        .raw  (coinQ_raw),
        .rise (rise_q)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
        .clk  (clk),
        .rst  (rst),
        .raw  (coinD_raw),
        .rise (rise_d)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_n (
        .clk  (clk),
        .rst  (rst),
        .raw  (coinN_raw),
        .rise (rise_n)
    );

    logic [1:0] n_events;
    logic       push_req;
    logic       multi_evt;
    coin_t      push_code;

    assign n_events  = 2'(rise_q) + 2'(rise_d) + 2'(rise_n);
    assign push_req  = (n_events == 2'd1);
    assign multi_evt = (n_events > 2'd1);

    always_comb begin
        push_code = COIN_NONE;
        if (rise_q)      push_code = COIN_Q;
        else if (rise_d) push_code = COIN_D;
        else if (rise_n) push_code = COIN_N;
    end

    // ---------------- FIFO ----------------
    state_t          state;
    state_t          state_nx;
    logic [GW-1:0]   gap_cnt;
    coin_t           cur_code;
    coin_t           mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop;
    logic            push_ok;
    logic            drop;

    assign full = (fifo_count == CW'(FIFO_DEPTH));
    assign pop  = (state == ST_IDLE) && (fifo_count != '0) && !hold;
    // A same-cycle pop frees the head slot, so a push into a full queue still lands.
    assign push_ok = push_req && (!full || pop);
    assign drop    = multi_evt || (push_req && full && !pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            reject     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= COIN_NONE;
            end
        end else begin
            reject <= drop;
            if (push_ok) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- output FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            cur_code <= COIN_NONE;
        end else begin
            state   <= state_nx;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
            if (pop) begin
                // Reads the pre-edge head, so a simultaneous push into the same slot is safe.
                cur_code <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        state_nx = state;
        inQ      = 1'b0;
        inD      = 1'b0;
        inN      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pop) state_nx = ST_EMIT;
            end
            ST_EMIT: begin
                inQ      = (cur_code == COIN_Q);
                inD      = (cur_code == COIN_D);
                inN      = (cur_code == COIN_N);
                state_nx = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
